// File: rtl/scpad_tile_sequencer_if.sv
// Tile-sequencer bus: requester descriptors in, address-mapper beat stream out.
// The slave modport is the sequencer; the master modport is the requester/crossbar side.
interface scpad_tile_sequencer_if #(
    parameter int NUM_COLS      = 32,
    parameter int ROW_IDX_WIDTH = 10,
    parameter int DIM_WIDTH     = $clog2(NUM_COLS) + 1,
    parameter int IDX_WIDTH     = $clog2(NUM_COLS)
);
    logic [1:0]                    req_valid;
    logic [1:0]                    req_ready;
    logic [1:0]                    req_row_or_col;
    logic [1:0][ROW_IDX_WIDTH-1:0] req_spad_addr;
    logic [1:0][DIM_WIDTH-1:0]     req_num_rows;
    logic [1:0][DIM_WIDTH-1:0]     req_num_cols;

    logic                          am_row_or_col;
    logic [ROW_IDX_WIDTH-1:0]      am_spad_addr;
    logic [DIM_WIDTH-1:0]          am_num_rows;
    logic [DIM_WIDTH-1:0]          am_num_cols;
    logic [IDX_WIDTH-1:0]          am_row_id;
    logic [IDX_WIDTH-1:0]          am_col_id;

    logic                          beat_valid;
    logic                          beat_ready;
    logic                          beat_last;
    logic                          beat_owner;
    logic                          done;
    logic                          done_owner;
    logic                          busy;

    modport master (
        output req_valid, req_row_or_col, req_spad_addr, req_num_rows, req_num_cols, beat_ready,
        input  req_ready, am_row_or_col, am_spad_addr, am_num_rows, am_num_cols,
               am_row_id, am_col_id, beat_valid, beat_last, beat_owner, done, done_owner, busy
    );

    modport slave (
        input  req_valid, req_row_or_col, req_spad_addr, req_num_rows, req_num_cols, beat_ready,
        output req_ready, am_row_or_col, am_spad_addr, am_num_rows, am_num_cols,
               am_row_id, am_col_id, beat_valid, beat_last, beat_owner, done, done_owner, busy
    );
endinterface

// File: rtl/scpad_tile_sequencer.sv
// Round-robin tile sequencer: accepts one of two tile descriptors and steps
// row_id/col_id one beat per crossbar handshake into the scratchpad address mapper.
//
// state | meaning
// IDLE  | arbitrating; req_ready asserted combinationally for the winner
// ISSUE | presenting beats of the captured tile, one per beat_ready
module scpad_tile_sequencer #(
    parameter int NUM_COLS      = 32,
    parameter int ROW_IDX_WIDTH = 10,
    parameter int DIM_WIDTH     = $clog2(NUM_COLS) + 1,
    parameter int IDX_WIDTH     = $clog2(NUM_COLS)
) (
    input logic                   CLK,
    input logic                   nRST,
    scpad_tile_sequencer_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    localparam logic [DIM_WIDTH-1:0] MAX_DIM = DIM_WIDTH'(NUM_COLS);
    localparam logic [DIM_WIDTH-1:0] ONE_DIM = DIM_WIDTH'(1);

    state_t                   state_q;
    logic                     prio_q;
    logic [IDX_WIDTH-1:0]     cnt_q;
    logic [DIM_WIDTH-1:0]     beats_q;
    logic                     owner_q;
    logic                     last_q;
    logic                     done_q;
    logic                     done_owner_q;
    logic                     row_or_col_q;
    logic [ROW_IDX_WIDTH-1:0] spad_q;
    logic [DIM_WIDTH-1:0]     rows_q;
    logic [DIM_WIDTH-1:0]     cols_q;
    logic [IDX_WIDTH-1:0]     row_id_q;
    logic [IDX_WIDTH-1:0]     col_id_q;

    logic                     grant;
    logic                     accept;
    logic [DIM_WIDTH-1:0]     g_rows;
    logic [DIM_WIDTH-1:0]     g_cols;
    logic [DIM_WIDTH-1:0]     g_beats;
    logic [DIM_WIDTH-1:0]     cnt_nxt;

    always_comb begin
        grant = (&bus.req_valid) ? prio_q : bus.req_valid[1];
        // Gated by nRST so req_ready reads 0 while reset is held
        accept  = nRST && (state_q == IDLE) && (|bus.req_valid);
        g_rows  = (bus.req_num_rows[grant] > MAX_DIM) ? MAX_DIM : bus.req_num_rows[grant];
        g_cols  = (bus.req_num_cols[grant] > MAX_DIM) ? MAX_DIM : bus.req_num_cols[grant];
        g_beats = bus.req_row_or_col[grant] ? g_rows : g_cols;
        cnt_nxt = DIM_WIDTH'(cnt_q) + ONE_DIM;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            prio_q       <= 1'b0;
            cnt_q        <= '0;
            beats_q      <= '0;
            owner_q      <= 1'b0;
            last_q       <= 1'b0;
            done_q       <= 1'b0;
            done_owner_q <= 1'b0;
            row_or_col_q <= 1'b0;
            spad_q       <= '0;
            rows_q       <= '0;
            cols_q       <= '0;
            row_id_q     <= '0;
            col_id_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        prio_q       <= ~grant;
                        owner_q      <= grant;
                        row_or_col_q <= bus.req_row_or_col[grant];
                        spad_q       <= bus.req_spad_addr[grant];
                        rows_q       <= g_rows;
                        cols_q       <= g_cols;
                        beats_q      <= g_beats;
                        cnt_q        <= '0;
                        row_id_q     <= '0;
                        col_id_q     <= '0;
                        // Zero-length tiles complete without ever leaving IDLE
                        if (g_beats == '0) begin
                            done_q       <= 1'b1;
                            done_owner_q <= grant;
                        end else begin
                            state_q <= ISSUE;
                            last_q  <= (g_beats == ONE_DIM);
                        end
                    end
                end
                ISSUE: begin
                    if (bus.beat_ready) begin
                        if (last_q) begin
                            state_q      <= IDLE;
                            last_q       <= 1'b0;
                            done_q       <= 1'b1;
                            done_owner_q <= owner_q;
                        end else begin
                            cnt_q  <= cnt_nxt[IDX_WIDTH-1:0];
                            last_q <= (cnt_nxt == (beats_q - ONE_DIM));
                            if (row_or_col_q) begin
                                row_id_q <= cnt_nxt[IDX_WIDTH-1:0];
                            end else begin
                                col_id_q <= cnt_nxt[IDX_WIDTH-1:0];
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign bus.req_ready     = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign bus.am_row_or_col = row_or_col_q;
    assign bus.am_spad_addr  = spad_q;
    assign bus.am_num_rows   = rows_q;
    assign bus.am_num_cols   = cols_q;
    assign bus.am_row_id     = row_id_q;
    assign bus.am_col_id     = col_id_q;
    assign bus.beat_valid    = (state_q == ISSUE);
    assign bus.beat_last     = last_q;
    assign bus.beat_owner    = owner_q;
    assign bus.done          = done_q;
    assign bus.done_owner    = done_owner_q;
    assign bus.busy          = (state_q == ISSUE);
endmodule

// File: doc/scpad_tile_sequencer.md
# scpad_tile_sequencer

Sequences tile accesses into the scratchpad address mapper. Two requesters (0: frontend/compute, 1: backend/DRAM) each present a tile descriptor. The block arbitrates round-robin, captures the winner, and steps `row_id`/`col_id` one beat per handshake with the bank crossbar. Its outputs drive the address mapper's `row_or_col`, `spad_addr`, `num_rows`, `num_cols`, `row_id` and `col_id` inputs directly.

## Interface
Parameters:
- NUM_COLS, 32, number of banks; maximum tile dimension (power of two)
- ROW_IDX_WIDTH, 10, scratchpad slot address width
- DIM_WIDTH, $clog2(NUM_COLS)+1, width of num_rows/num_cols (must represent NUM_COLS)
- IDX_WIDTH, $clog2(NUM_COLS), width of row_id/col_id

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- req_valid  in  [2]  requester i has a tile descriptor
- req_ready  out  [2]  descriptor i accepted this cycle
- req_row_or_col  in  [2]  1 = row-major (one row per beat), 0 = column-major (one column per beat)
- req_spad_addr  in  [2][ROW_IDX_WIDTH]  tile base slot
- req_num_rows  in  [2][DIM_WIDTH]  tile rows
- req_num_cols  in  [2][DIM_WIDTH]  tile columns
- am_row_or_col, am_spad_addr, am_num_rows, am_num_cols  out  1/ROW_IDX_WIDTH/DIM_WIDTH/DIM_WIDTH  captured descriptor to the address mapper
- am_row_id, am_col_id  out  IDX_WIDTH  current beat index
- beat_valid  out  1  address-mapper inputs form a valid beat
- beat_ready  in  1  crossbar consumes the beat
- beat_last  out  1  current beat is the final beat of the tile
- beat_owner  out  1  requester that owns the current tile
- done  out  1  one-cycle pulse: tile complete
- done_owner  out  1  owner of the completed tile
- busy  out  1  FSM not IDLE

## Operation
- The FSM has two states: IDLE and ISSUE.
- **IDLE:**
  - Arbitrate over `req_valid`.
  - If both requesters are valid, grant the one selected by the priority pointer.
  - Assert `req_ready` only for the granted requester, combinationally in the same cycle.
  - On the handshake, capture the descriptor, set `beat_owner`, clear the beat counter, and go to ISSUE.
  - Set the priority pointer to the other requester after every grant.
- **Capture rules:**
  - Saturate num_rows and num_cols to NUM_COLS if larger.
  - Beat count N = num_rows when row_or_col=1, else num_cols.
- **Zero-length tile (N=0):**
  - The descriptor is accepted.
  - No beat is issued; the FSM stays in IDLE.
  - `done` and `done_owner` pulse in the next cycle.
- **ISSUE:**
  - `beat_valid` = 1.
  - Row-major: am_row_id = counter, am_col_id = 0. Column-major: am_col_id = counter, am_row_id = 0.
  - `beat_last` = (counter == N-1).
  - When beat_valid && beat_ready, increment the counter.
  - When beat_valid && beat_ready && beat_last, go to IDLE and pulse `done`/`done_owner` in the next cycle.
- `req_ready` is 0 for both requesters while in ISSUE.
- `spad_addr` passes through unmodified; the address mapper adds the row offset.
- The counter never exceeds N-1 and does not wrap.

## Timing
- **Reset:**
  - FSM goes to IDLE, counter = 0, priority pointer = requester 0.
  - All outputs are 0: req_ready, beat_valid, beat_last, beat_owner, done, done_owner, busy, and all am_* outputs.
  - Reset asserted mid-tile abandons the tile immediately; no `done` is produced.
- **Latency:**
  - Descriptor accepted at cycle t gives first beat_valid at t+1.
  - With beat_ready held high, beats occupy t+1 … t+N.
  - `done` pulses at t+N+1.
  - The next request can be accepted at t+N+1, so there is one bubble between tiles.
- **Stability:** while beat_valid && !beat_ready, every am_* output, beat_last and beat_owner hold constant.
- **Requester rule:** a requester keeps its fields stable while req_valid && !req_ready. The sequencer does not depend on a requester deasserting.
- **Simultaneous events:**
  - `done` for tile k and acceptance of tile k+1 occur in the same cycle.
  - A zero-length `done` can coincide with a new acceptance.
- **busy:** 1 exactly while in ISSUE.

## Test plan
- Single requester 0, row-major, spad_addr=0x40, 4×8, beat_ready=1 → beats at t+1..t+4 with row_id 0,1,2,3 and col_id=0; beat_last only on row_id=3; done at t+5 with done_owner=0.
- Column-major 3×5, beat_ready toggling 1,0,1,0,… → exactly 5 beats with col_id 0..4; outputs held during stalls; done one cycle after the 5th handshake.
- Both requesters valid continuously, each sending 2×2 tiles → grants alternate 0,1,0,1 starting with 0; back-to-back tiles separated by exactly one idle cycle.
- num_rows=0 row-major → req_ready pulses, no beat_valid, done pulses next cycle; num_cols=40 column-major saturates to 32 beats, last col_id=31.
- nRST asserted during beat 2 of an 8-beat tile → all outputs 0 immediately with no done; after release, requester 1 alone is granted and its tile runs correctly.
